usb_data_buffer: RTL and testbench

Byte FIFO between the USB receiver/transmitter and the AHB-Lite slave interface of the bulk-transfer endpoint. It captures every byte `usb_rx` asserts with `store_rx_packet_data` and returns them to the AHB side via `get_rx_data`. It also accepts bytes from the AHB side (`store_tx_data`) and hands them to the USB transmitter via `get_tx_packet_data`. Occupancy is reported continuously so the protocol controller can gate packet transfers.

---
 rtl/usb_data_buffer.sv | 111 +++++++++++
 tb/tb_usb_data_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO shared by the USB RX/TX path and the AHB slave; a read loads its output register on the strobe edge.
// Full writes and empty reads are dropped; the USB_BUFFER_ERR_FLAGS_EN macro adds sticky overflow/underflow flags.
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      store_rx_packet_data,
  input  logic [DATA_W-1:0]         rx_packet_data,
  input  logic                      store_tx_data,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      get_rx_data,
  output logic [DATA_W-1:0]         rx_data,
  input  logic                      get_tx_packet_data,
  output logic [DATA_W-1:0]         tx_packet_data,
`ifdef USB_BUFFER_ERR_FLAGS_EN
  output logic                      buffer_overflow,
  output logic                      buffer_underflow,
`endif
  output logic [$clog2(DEPTH):0]    buffer_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     occ;

  logic              any_wr;
  logic              any_rd;
  logic              is_full;
  logic              is_empty;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_dat;

  assign is_full  = (occ == CW'(DEPTH));
  assign is_empty = (occ == '0);
  assign any_wr   = store_rx_packet_data | store_tx_data;
  assign any_rd   = get_rx_data | get_tx_packet_data;
  assign wr_dat   = store_rx_packet_data ? rx_packet_data : tx_data;
  // A read frees the slot the write lands in, so a full buffer still accepts a write alongside a read.
  assign rd_ok    = any_rd & ~is_empty;
  assign wr_ok    = any_wr & (~is_full | rd_ok);

  assign buffer_occupancy = occ;

  always_ff @(posedge clk) begin
    if (!clear && wr_ok) begin
      mem[wptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr           <= '0;
      rptr           <= '0;
      occ            <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else if (clear) begin
      wptr           <= '0;
      rptr           <= '0;
      occ            <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
        if (get_tx_packet_data) begin
          tx_packet_data <= mem[rptr];
        end else begin
          rx_data <= mem[rptr];
        end
      end
      if (wr_ok && !rd_ok) begin
        occ <= occ + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        occ <= occ - CW'(1);
      end
    end
  end

`ifdef USB_BUFFER_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buffer_overflow  <= 1'b0;
      buffer_underflow <= 1'b0;
    end else if (clear) begin
      buffer_overflow  <= 1'b0;
      buffer_underflow <= 1'b0;
    end else begin
      // The AHB byte losing a write collision counts as dropped too.
      if ((any_wr && !wr_ok) || (store_rx_packet_data && store_tx_data)) begin
        buffer_overflow <= 1'b1;
      end
      if (any_rd && is_empty) begin
        buffer_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scenario bench for usb_data_buffer against a queue-based reference model.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
`ifdef USB_BUFFER_ERR_FLAGS_EN
  logic       buffer_overflow;
  logic       buffer_underflow;
`endif

  usb_data_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
`ifdef USB_BUFFER_ERR_FLAGS_EN
    .buffer_overflow      (buffer_overflow),
    .buffer_underflow     (buffer_underflow),
`endif
    .buffer_occupancy     (buffer_occupancy)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a plain queue of bytes plus the two output registers and flags.
  logic [7:0] q[$];
  logic [7:0] m_rx;
  logic [7:0] m_tx;
  bit         m_ov;
  bit         m_un;

  task automatic model_reset();
    q.delete();
    m_rx = 8'h00;
    m_tx = 8'h00;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic model_step(input logic srx, input logic [7:0] drx, input logic stx,
                            input logic [7:0] dtx, input logic grx, input logic gtx,
                            input logic clr);
    int         n;
    bit         rd;
    logic [7:0] v;
    if (clr) begin
      model_reset();
    end else begin
      n  = q.size();
      rd = (grx || gtx) && (n > 0);
      if ((grx || gtx) && n == 0) m_un = 1'b1;
      if (srx && stx) m_ov = 1'b1;
      if (rd) begin
        v = q.pop_front();
        if (gtx) m_tx = v;
        else     m_rx = v;
      end
      if (srx || stx) begin
        if (n < DEPTH || rd) q.push_back(srx ? drx : dtx);
        else                 m_ov = 1'b1;
      end
    end
  endtask

  // Applies one clock of stimulus, then leaves the bench 1 ns after the edge.
  task automatic cycle(input logic srx, input logic [7:0] drx, input logic stx,
                       input logic [7:0] dtx, input logic grx, input logic gtx,
                       input logic clr);
    store_rx_packet_data = srx;
    rx_packet_data       = drx;
    store_tx_data        = stx;
    tx_data              = dtx;
    get_rx_data          = grx;
    get_tx_packet_data   = gtx;
    clear                = clr;
    @(posedge clk);
    #1;
    model_step(srx, drx, stx, dtx, grx, gtx, clr);
    store_rx_packet_data = 1'b0;
    store_tx_data        = 1'b0;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    clear                = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_state: rx=%h tx=%h occ=%0d, want 00 00 0", rx_data, tx_packet_data, buffer_occupancy);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cycle(1, 8'h33, 0, 8'h00, 0, 0, 0);
    cycle(1, 8'h44, 0, 8'h00, 0, 1, 0);
    #3 n_rst = 1'b0;
    #1;
    vectors++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_async: rx=%h tx=%h occ=%0d, want 00 00 0", rx_data, tx_packet_data, buffer_occupancy);
    end
    model_reset();
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 8'hA5, 0, 8'h00, 0, 0, 0);
    vectors++;
    if (buffer_occupancy !== 7'd1) begin
      miscompares++;
      $display("FAIL reset_write_occ: got %0d want 1", buffer_occupancy);
    end
    cycle(0, 8'h00, 0, 8'h00, 1, 0, 0);
    vectors++;
    if (rx_data !== 8'hA5 || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_readback: rx=%h occ=%0d, want a5 0", rx_data, buffer_occupancy);
    end
  endtask

  task automatic test_order_wrap();
    for (int i = 0; i < 70; i++) begin
      cycle(1, 8'(i), 0, 8'h00, i >= 3, 0, 0);
      vectors++;
      if (buffer_occupancy !== 7'((i < 3) ? i + 1 : 3) || (i >= 3 && rx_data !== 8'(i - 3))) begin
        miscompares++;
        $display("FAIL order_wrap[%0d]: rx=%h occ=%0d, want %h %0d", i, rx_data, buffer_occupancy,
                 8'(i - 3), (i < 3) ? i + 1 : 3);
      end
    end
    for (int i = 67; i < 70; i++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0, 0);
      vectors++;
      if (rx_data !== 8'(i) || buffer_occupancy !== 7'(69 - i)) begin
        miscompares++;
        $display("FAIL order_drain[%0d]: rx=%h occ=%0d, want %h %0d", i, rx_data, buffer_occupancy, 8'(i), 69 - i);
      end
    end
  endtask

  task automatic test_full();
    cycle(0, 8'h00, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 65; i++) cycle(0, 8'h00, 1, 8'(8'h80 + i), 0, 0, 0);
    vectors++;
    if (buffer_occupancy !== 7'd64) begin
      miscompares++;
      $display("FAIL full_occ: got %0d want 64", buffer_occupancy);
    end
`ifdef USB_BUFFER_ERR_FLAGS_EN
    vectors++;
    if (buffer_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_overflow_flag: got %b want 1", buffer_overflow);
    end
`endif
    for (int i = 0; i < 64; i++) begin
      cycle(0, 8'h00, 0, 8'h00, 0, 1, 0);
      vectors++;
      if (tx_packet_data !== 8'(8'h80 + i) || buffer_occupancy !== 7'(63 - i)) begin
        miscompares++;
        $display("FAIL full_readback[%0d]: tx=%h occ=%0d, want %h %0d", i, tx_packet_data, buffer_occupancy,
                 8'(8'h80 + i), 63 - i);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] prev_rx;
    prev_rx = m_rx;
    cycle(1, 8'h11, 1, 8'h22, 0, 0, 0);
    vectors++;
    if (buffer_occupancy !== 7'd1) begin
      miscompares++;
      $display("FAIL collision_occ: got %0d want 1", buffer_occupancy);
    end
    cycle(0, 8'h00, 0, 8'h00, 1, 1, 0);
    vectors++;
    if (tx_packet_data !== 8'h11 || rx_data !== prev_rx || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL collision_read: tx=%h rx=%h occ=%0d, want 11 %h 0", tx_packet_data, rx_data,
               buffer_occupancy, prev_rx);
    end
  endtask

  task automatic test_full_rw();
    cycle(0, 8'h00, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 64; i++) cycle(1, 8'(i), 0, 8'h00, 0, 0, 0);
    cycle(1, 8'h7E, 0, 8'h00, 0, 1, 0);
    vectors++;
    if (buffer_occupancy !== 7'd64 || tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL full_rw: occ=%0d tx=%h, want 64 00", buffer_occupancy, tx_packet_data);
    end
    for (int i = 1; i <= 64; i++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0, 0);
      vectors++;
      if (rx_data !== ((i == 64) ? 8'h7E : 8'(i))) begin
        miscompares++;
        $display("FAIL full_rw_drain[%0d]: rx=%h want %h", i, rx_data, (i == 64) ? 8'h7E : 8'(i));
      end
    end
  endtask

  task automatic test_clear_empty();
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'hC0 + i), 0, 8'h00, 0, i == 2, 0);
    cycle(1, 8'h99, 0, 8'h00, 0, 0, 1);
    vectors++;
    if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      miscompares++;
      $display("FAIL clear: occ=%0d rx=%h tx=%h, want 0 00 00", buffer_occupancy, rx_data, tx_packet_data);
    end
    cycle(0, 8'h00, 0, 8'h00, 1, 0, 0);
    vectors++;
    if (rx_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL empty_read: rx=%h occ=%0d, want 00 0", rx_data, buffer_occupancy);
    end
`ifdef USB_BUFFER_ERR_FLAGS_EN
    vectors++;
    if (buffer_underflow !== 1'b1 || buffer_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_flags: un=%b ov=%b, want 1 0", buffer_underflow, buffer_overflow);
    end
`endif
  endtask

  task automatic test_random();
    logic srx, stx, grx, gtx, clr;
    for (int i = 0; i < 600; i++) begin
      // Bias towards writes in the first half so the buffer reaches full.
      srx = ($urandom_range(0, 99) < ((i < 300) ? 60 : 35));
      stx = ($urandom_range(0, 99) < 30);
      grx = ($urandom_range(0, 99) < ((i < 300) ? 25 : 45));
      gtx = ($urandom_range(0, 99) < 20);
      clr = ($urandom_range(0, 99) == 0);
      cycle(srx, 8'($urandom), stx, 8'($urandom), grx, gtx, clr);
      vectors++;
      if (buffer_occupancy !== 7'(q.size()) || rx_data !== m_rx || tx_packet_data !== m_tx) begin
        miscompares++;
        $display("FAIL random[%0d]: occ=%0d rx=%h tx=%h, want %0d %h %h", i, buffer_occupancy, rx_data,
                 tx_packet_data, q.size(), m_rx, m_tx);
      end
`ifdef USB_BUFFER_ERR_FLAGS_EN
      vectors++;
      if (buffer_overflow !== m_ov || buffer_underflow !== m_un) begin
        miscompares++;
        $display("FAIL random_flags[%0d]: ov=%b un=%b, want %b %b", i, buffer_overflow, buffer_underflow, m_ov, m_un);
      end
`endif
    end
  endtask

  initial begin
    n_rst                = 1'b0;
    clear                = 1'b0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    store_tx_data        = 1'b0;
    tx_data              = 8'h00;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    model_reset();
    test_reset();
    test_order_wrap();
    test_full();
    test_collision();
    test_full_rw();
    test_clear_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
